// File: rtl/alsu_arbiter.sv
// Two-requester round-robin front end for a single ALSU: grants one command at a time,
// screens illegal commands before they reach the ALSU and returns a tagged response.
module alsu_arbiter #(
    parameter string ALSU_PRIORITY = "A"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_a,
    input  logic [2:0] req0_b,
    input  logic [2:0] req0_opcode,
    input  logic [6:0] req0_ctrl,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_a,
    input  logic [2:0] req1_b,
    input  logic [2:0] req1_opcode,
    input  logic [6:0] req1_ctrl,
    output logic [2:0] alsu_a,
    output logic [2:0] alsu_b,
    output logic [2:0] alsu_opcode,
    output logic [6:0] alsu_ctrl,
    input  logic [5:0] alsu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [5:0] rsp_data,
    output logic       rsp_err
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned OUT_W  = 6;
    localparam int unsigned RED_A  = 3;
    localparam int unsigned RED_B  = 2;
    localparam int unsigned BYP_A  = 1;
    localparam int unsigned BYP_B  = 0;

    // Both-bypass is only well defined when the ALSU resolves it to one operand.
    localparam bit PRIO_OK = (ALSU_PRIORITY == "A") || (ALSU_PRIORITY == "B");

    typedef struct packed {
        logic [OP_W-1:0]   a;
        logic [OP_W-1:0]   b;
        logic [OP_W-1:0]   opcode;
        logic [CTRL_W-1:0] ctrl;
    } cmd_t;

    // NOP = bypass_A with a=0, which clears the ALSU result register.
    localparam cmd_t NOP_CMD = '{a: '0, b: '0, opcode: '0, ctrl: CTRL_W'(7'b0000010)};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;
    cmd_t   req0_cmd;
    cmd_t   req1_cmd;
    cmd_t   cmd_in;
    cmd_t   alsu_cmd;
    logic   prio;
    logic   sel_c;
    logic   accept_c;
    logic   illegal_c;

    function automatic logic is_illegal(input cmd_t c);
        logic byp_any;
        logic op_bad;
        logic red_bad;
        byp_any = c.ctrl[BYP_A] | c.ctrl[BYP_B];
        op_bad  = (c.opcode[2:1] == 2'b11);
        red_bad = (c.ctrl[RED_A] | c.ctrl[RED_B]) &&
                  (c.opcode >= 3'd2) && (c.opcode <= 3'd5);
        return (!byp_any && (op_bad || red_bad)) ||
               (c.ctrl[BYP_A] && c.ctrl[BYP_B] && !PRIO_OK);
    endfunction

    assign req0_cmd = {req0_a, req0_b, req0_opcode, req0_ctrl};
    assign req1_cmd = {req1_a, req1_b, req1_opcode, req1_ctrl};

    // Round-robin pick: prio names the favoured requester when both are valid.
    assign sel_c      = (req0_valid && req1_valid) ? prio : req1_valid;
    assign accept_c   = !rst && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept_c && !sel_c;
    assign req1_ready = accept_c && sel_c;
    assign cmd_in     = sel_c ? req1_cmd : req0_cmd;
    assign illegal_c  = is_illegal(cmd_in);

    assign alsu_a      = alsu_cmd.a;
    assign alsu_b      = alsu_cmd.b;
    assign alsu_opcode = alsu_cmd.opcode;
    assign alsu_ctrl   = alsu_cmd.ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = illegal_c ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command register doubles as the ALSU drive: loaded for one cycle, NOP otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio      <= 1'b0;
            alsu_cmd  <= NOP_CMD;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            alsu_cmd <= NOP_CMD;
            if (accept_c) begin
                prio   <= !sel_c;
                rsp_id <= sel_c;
                if (!illegal_c) alsu_cmd <= cmd_in;
            end
            if (accept_c && illegal_c) begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
            end else if (state == WAIT) begin
                rsp_valid <= 1'b1;
                rsp_data  <= OUT_W'(alsu_out);
                rsp_err   <= 1'b0;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alsu_arbiter.sv
// Directed bench for alsu_arbiter with a small registered ALSU model on the alsu_* port.
`timescale 1ns/1ps
module tb_alsu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_a, req0_b, req0_opcode, req1_a, req1_b, req1_opcode;
    logic [6:0] req0_ctrl, req1_ctrl;
    logic [2:0] alsu_a, alsu_b, alsu_opcode;
    logic [6:0] alsu_ctrl;
    logic [5:0] alsu_out;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [5:0] rsp_data;

    int checks = 0;
    int errors = 0;
    bit bad_drive = 0;
    bit both_ready = 0;

    alsu_arbiter #(.ALSU_PRIORITY("A")) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_opcode(req0_opcode), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_opcode(req1_opcode), .req1_ctrl(req1_ctrl),
        .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_opcode(alsu_opcode), .alsu_ctrl(alsu_ctrl),
        .alsu_out(alsu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // ALSU behaviour: one register stage, priority A, ctrl = {cin,sin,dir,redA,redB,bypA,bypB}.
    function automatic logic [5:0] alsu_f(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] op, input logic [6:0] c,
                                          input logic [5:0] cur);
        if (c[1]) return 6'(a);
        if (c[0]) return 6'(b);
        case (op)
            3'd0: return c[3] ? 6'(&a) : (c[2] ? 6'(&b) : 6'(a & b));
            3'd1: return c[3] ? 6'(^a) : (c[2] ? 6'(^b) : 6'(a ^ b));
            3'd2: return 6'(a) + 6'(b) + 6'(c[6]);
            3'd3: return 6'(a) * 6'(b);
            3'd4: return c[4] ? {cur[4:0], c[5]} : {c[5], cur[5:1]};
            3'd5: return c[4] ? {cur[4:0], cur[5]} : {cur[0], cur[5:1]};
            default: return 6'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) alsu_out <= 6'd0;
        else     alsu_out <= alsu_f(alsu_a, alsu_b, alsu_opcode, alsu_ctrl, alsu_out);
    end

    always @(negedge clk) begin
        if (!rst && alsu_opcode[2:1] == 2'b11 && alsu_ctrl[1:0] == 2'b00) bad_drive = 1;
        if (req0_ready && req1_ready) both_ready = 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int who, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] op, input logic [6:0] c);
        if (who == 0) begin
            req0_a = a; req0_b = b; req0_opcode = op; req0_ctrl = c; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_opcode = op; req1_ctrl = c; req1_valid = 1'b1;
        end
    endtask

    // One full transaction with rsp_ready=1; checks latency, id, data and error flag.
    task automatic issue(input string tag, input int who, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] op, input logic [6:0] c,
                         input logic exp_err, input logic [5:0] exp_data);
        bit got;
        int lat;
        rsp_ready = 1'b1;
        drive(who, a, b, op, c);
        #1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) got = 1;
            else tick();
        end
        check({tag, "_grant"}, 32'(got), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (got) begin
            lat = 1;
            while (!rsp_valid && lat < 10) begin
                tick();
                lat++;
            end
            check({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd3);
            check({tag, "_id"}, 32'(rsp_id), 32'(who));
            check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
            check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
            tick();
            check({tag, "_done"}, 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        logic       ids[4];
        logic [5:0] dat[4];
        logic       s_id, s_err;
        logic [5:0] s_data;
        int         n;

        rst = 1'b1;
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        drive(0, 3'd1, 3'd1, 3'd2, 7'd0);
        drive(1, 3'd1, 3'd1, 3'd2, 7'd0);
        req1_valid = 1'b0;
        tick();
        tick();
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fields", {rsp_id, rsp_err, rsp_data}, 32'd0);
        check("rst_alsu", {alsu_a, alsu_b, alsu_opcode, alsu_ctrl}, 32'h0002);
        req0_valid = 1'b0;
        #3 rst = 1'b0;
        tick();

        // Add with carry from req0, stepped cycle by cycle.
        drive(0, 3'd3, 3'd2, 3'b010, 7'b1000000);
        #1;
        check("add_ready0", 32'(req0_ready), 32'd1);
        check("add_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check("add_issue_drive", {alsu_a, alsu_b, alsu_opcode, alsu_ctrl}, {16'd0, 3'd3, 3'd2, 3'b010, 7'h40});
        check("add_issue_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("add_wait_nop", {alsu_a, alsu_b, alsu_opcode, alsu_ctrl}, 32'h0002);
        check("add_wait_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("add_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {24'd0, 1'b1, 1'b0, 1'b0, 6'd6});
        tick();
        check("add_done", 32'(rsp_valid), 32'd0);

        issue("op110", 1, 3'd2, 3'd3, 3'b110, 7'd0, 1'b1, 6'd0);

        // Both requesters hammering: grants must alternate starting with req0.
        drive(0, 3'd1, 3'd1, 3'b010, 7'd0);
        drive(1, 3'd5, 3'd3, 3'b001, 7'd0);
        rsp_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            tick();
            if (rsp_valid) begin
                ids[n] = rsp_id;
                dat[n] = rsp_data;
                n++;
                if (n == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("rr_count", 32'(n), 32'd4);
        if (n == 4) begin
            check("rr_ids", {28'd0, ids[0], ids[1], ids[2], ids[3]}, 32'b0101);
            check("rr_data", {8'd0, dat[0], dat[1], dat[2], dat[3]}, {8'd0, 6'd2, 6'd6, 6'd2, 6'd6});
        end

        issue("red_add", 0, 3'd1, 3'd1, 3'b011, 7'b0001000, 1'b1, 6'd0);
        issue("red_and", 0, 3'd7, 3'd0, 3'b000, 7'b0001000, 1'b0, 6'd1);
        issue("redb_rot", 1, 3'd1, 3'd1, 3'b101, 7'b0000100, 1'b1, 6'd0);
        issue("byp_op111", 1, 3'd5, 3'd2, 3'b111, 7'b0000010, 1'b0, 6'd5);
        issue("byp_both", 0, 3'd4, 3'd1, 3'b000, 7'b0000011, 1'b0, 6'd4);
        issue("shl", 0, 3'd0, 3'd0, 3'b100, 7'b0110000, 1'b0, 6'd1);
        issue("shr", 1, 3'd0, 3'd0, 3'b100, 7'b0100000, 1'b0, 6'd32);
        issue("rot", 0, 3'd7, 3'd7, 3'b101, 7'b0010000, 1'b0, 6'd0);
        issue("mult", 1, 3'd7, 3'd6, 3'b011, 7'd0, 1'b0, 6'd42);

        // Response back-pressure: fields frozen, no grants, IDLE visited after release.
        rsp_ready = 1'b0;
        drive(0, 3'd6, 3'd3, 3'b001, 7'd0);
        #1;
        check("bp_grant", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        check("bp_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {24'd0, 1'b1, 1'b0, 1'b0, 6'd5});
        s_id = rsp_id;
        s_err = rsp_err;
        s_data = rsp_data;
        drive(0, 3'd1, 3'd2, 3'b010, 7'd0);
        drive(1, 3'd1, 3'd2, 3'b010, 7'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready},
                  {22'd0, 1'b1, s_id, s_err, s_data, 1'b0, 1'b0});
        end
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("hs_no_grant", 32'(req0_ready), 32'd0);
        tick();
        check("hs_idle", {rsp_valid, req0_ready}, 32'b01);
        req0_valid = 1'b0;
        tick();

        // Reset while WAIT: response dropped, pointer back to req0.
        drive(0, 3'd1, 3'd2, 3'b010, 7'd0);
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 32'd0);
        check("mid_rst_alsu", {alsu_a, alsu_b, alsu_opcode, alsu_ctrl}, 32'h0002);
        tick();
        tick();
        check("mid_rst_hold", 32'(rsp_valid), 32'd0);
        #3 rst = 1'b0;
        tick();
        check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        drive(0, 3'd7, 3'd7, 3'b010, 7'b1000000);
        drive(1, 3'd1, 3'd1, 3'b010, 7'd0);
        #1;
        check("post_rst_ptr", {req0_ready, req1_ready}, 32'b10);
        req1_valid = 1'b0;
        issue("post_rst", 0, 3'd7, 3'd7, 3'b010, 7'b1000000, 1'b0, 6'd15);

        check("never_drove_illegal", 32'(bad_drive), 32'd0);
        check("ready_exclusive", 32'(both_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
